freq_div_ratio_sched: RTL and testbench

Divide-ratio scheduler for the 8-LED frequency-divider pipeline. Holds a small program of (ratio, dwell) entries and drives the divider's `datain` bus, stepping to the next ratio only at a divider period boundary, which is the falling edge of the divider's MSB LED output. It sits between a host/config source and the divider, replacing the hand-driven `datain` sequencing used in bench-level bring-up.

---
 rtl/freq_div_ratio_sched.sv | 166 ++++++++++++++++
 tb/tb_freq_div_ratio_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_div_ratio_sched.sv
// Divide-ratio scheduler: steps the divider's datain through a programmed list of
// (ratio, dwell) entries, advancing only on falling edges of the divider MSB.
module freq_div_ratio_sched #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int DWELL_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [7:0]         cfg_ratio,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [AW-1:0]      cfg_last,
  input  logic               cfg_loop,
  input  logic               start,
  input  logic               stop,
  input  logic               div_tick,
  output logic [7:0]         datain,
  output logic [AW-1:0]      entry_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]         ratio_tab [DEPTH];
  logic [DWELL_W-1:0] dwell_tab [DEPTH];

  logic               tick_d_reg;
  logic               fall_reg;
  logic [7:0]         datain_reg;
  logic [AW-1:0]      idx_reg;
  logic [AW-1:0]      last_reg;
  logic               loop_reg;
  logic [DWELL_W-1:0] cnt_reg;
  logic [DWELL_W-1:0] lim_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               load_en;
  logic [AW-1:0]      load_addr;
  logic               cnt_inc;
  logic               capture;
  logic               done_next;
  logic [7:0]         load_ratio;
  logic [DWELL_W-1:0] load_dwell;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ratio_tab[i] <= '0;
        dwell_tab[i] <= '0;
      end
    end else if (cfg_we) begin
      ratio_tab[cfg_addr] <= cfg_ratio;
      dwell_tab[cfg_addr] <= cfg_dwell;
    end
  end

  // The fall is registered so every boundary decision uses only flopped inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_d_reg <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      tick_d_reg <= div_tick;
      fall_reg   <= tick_d_reg & ~div_tick;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    load_addr  = '0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start && !stop) begin
          state_next = S_RUN;
          capture    = 1'b1;
          load_en    = 1'b1;
          load_addr  = '0;
        end
      end
      S_RUN: begin
        if (fall_reg) begin
          if (cnt_reg == lim_reg) begin
            if (idx_reg < last_reg) begin
              load_en   = 1'b1;
              load_addr = idx_reg + 1'b1;
            end else if (loop_reg) begin
              load_en   = 1'b1;
              load_addr = '0;
            end else begin
              state_next = S_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        // A stop on an advance boundary lets the advance happen first.
        if (stop && state_next == S_RUN) begin
          state_next = S_STOPPING;
        end
      end
      S_STOPPING: begin
        if (fall_reg) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Entry values are latched at load time, so later table writes cannot disturb
  // the entry currently being applied.
  assign load_ratio = ratio_tab[load_addr];
  assign load_dwell = dwell_tab[load_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      datain_reg <= 8'h01;
      idx_reg    <= '0;
      last_reg   <= '0;
      loop_reg   <= 1'b0;
      cnt_reg    <= '0;
      lim_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= done_next;
      if (capture) begin
        last_reg <= cfg_last;
        loop_reg <= cfg_loop;
      end
      if (load_en) begin
        idx_reg    <= load_addr;
        datain_reg <= (load_ratio == 8'h00) ? 8'h01 : load_ratio;
        lim_reg    <= (load_dwell == '0) ? '0 : load_dwell - 1'b1;
        cnt_reg    <= '0;
      end else if (cnt_inc) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign datain    = datain_reg;
  assign entry_idx = idx_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_freq_div_ratio_sched.sv
// Bench for freq_div_ratio_sched: a per-cycle behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_freq_div_ratio_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_ratio;
  logic [7:0] cfg_dwell;
  logic [1:0] cfg_last;
  logic       cfg_loop;
  logic       start;
  logic       stop;
  logic       div_tick;
  logic [7:0] datain;
  logic [1:0] entry_idx;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  freq_div_ratio_sched #(.DEPTH(4), .AW(2), .DWELL_W(8)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_ratio(cfg_ratio), .cfg_dwell(cfg_dwell), .cfg_last(cfg_last),
    .cfg_loop(cfg_loop), .start(start), .stop(stop), .div_tick(div_tick),
    .datain(datain), .entry_idx(entry_idx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: counts whole divider periods per entry.
  logic [7:0] m_ratio [4];
  logic [7:0] m_dwell [4];
  int         m_mode;   // 0 idle, 1 run, 2 stopping
  int         m_need;
  int         m_count;
  logic [7:0] m_datain;
  logic [1:0] m_idx;
  logic [1:0] m_last;
  logic       m_loop, m_busy, m_done, m_prev, m_pend, m_fall_now, m_ended;

  task m_load(input int i);
    m_idx    = 2'(i);
    m_datain = (m_ratio[i] == 8'h00) ? 8'h01 : m_ratio[i];
    m_need   = (m_dwell[i] == 8'h00) ? 1 : int'(m_dwell[i]);
    m_count  = 0;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin m_ratio[i] = 8'h00; m_dwell[i] = 8'h00; end
      m_mode = 0; m_need = 1; m_count = 0; m_datain = 8'h01; m_idx = 2'd0;
      m_last = 2'd0; m_loop = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_prev = 1'b0; m_pend = 1'b0;
    end else begin
      m_fall_now = m_pend;
      m_pend     = m_prev && !div_tick;
      m_prev     = div_tick;
      m_done     = 1'b0;
      m_ended    = 1'b0;
      case (m_mode)
        0: if (start && !stop) begin
             m_last = cfg_last; m_loop = cfg_loop; m_load(0); m_mode = 1;
           end
        1: begin
             if (m_fall_now) begin
               m_count++;
               if (m_count == m_need) begin
                 if (m_idx < m_last) m_load(int'(m_idx) + 1);
                 else if (m_loop) m_load(0);
                 else begin m_mode = 0; m_done = 1'b1; m_ended = 1'b1; end
               end
             end
             if (stop && !m_ended) m_mode = 2;
           end
        default: if (m_fall_now) begin m_mode = 0; m_done = 1'b1; end
      endcase
      m_busy = (m_mode != 0);
      if (cfg_we) begin m_ratio[cfg_addr] = cfg_ratio; m_dwell[cfg_addr] = cfg_dwell; end
    end
  end

  always @(negedge clock) begin
    if (chk_en)
      chk("model", {20'd0, datain, entry_idx, busy, done},
                   {20'd0, m_datain, m_idx, m_busy, m_done});
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] r, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_ratio = r; cfg_dwell = d;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] last, input logic lp);
    start = 1'b1; cfg_last = last; cfg_loop = lp;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Returns at the negedge right after the boundary's effect is visible.
  task automatic do_fall();
    div_tick = 1'b1;
    @(negedge clock);
    div_tick = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic fall_with_stop();
    div_tick = 1'b1;
    @(negedge clock);
    div_tick = 1'b0;
    @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
  endtask

  logic [1:0] loop_seq [6];

  initial begin
    reset = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_ratio = 0; cfg_dwell = 0;
    cfg_last = 0; cfg_loop = 0; start = 0; stop = 0; div_tick = 0;
    loop_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    // Reset with random inputs
    repeat (3) begin
      cfg_we = 1'($urandom); cfg_addr = 2'($urandom); cfg_ratio = 8'($urandom);
      cfg_dwell = 8'($urandom); cfg_last = 2'($urandom); cfg_loop = 1'($urandom);
      start = 1'($urandom); stop = 1'($urandom); div_tick = 1'($urandom);
      @(negedge clock);
    end
    reset = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_ratio = 0; cfg_dwell = 0;
    cfg_last = 0; cfg_loop = 0; start = 0; stop = 0; div_tick = 0;
    @(negedge clock);
    chk_en = 1'b1;
    chk("rst_datain", datain, 8'h01);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", entry_idx, 2'd0);
    do_fall(); do_fall();
    chk("idle_fall_busy", busy, 1'b0);
    chk("idle_fall_datain", datain, 8'h01);

    // Single entry
    wr(2'd0, 8'h05, 8'd3);
    do_start(2'd0, 1'b0);
    chk("single_start_datain", datain, 8'h05);
    chk("single_start_busy", busy, 1'b1);
    do_fall(); do_fall();
    chk("single_2falls_done", done, 1'b0);
    chk("single_2falls_busy", busy, 1'b1);
    do_fall();
    chk("single_done", done, 1'b1);
    chk("single_end_busy", busy, 1'b0);
    chk("single_end_datain", datain, 8'h05);
    @(negedge clock);
    chk("single_done_pulse", done, 1'b0);

    // Two-entry sequence
    wr(2'd0, 8'h05, 8'd2);
    wr(2'd1, 8'h10, 8'd1);
    do_start(2'd1, 1'b0);
    do_fall();
    chk("two_fall1_datain", datain, 8'h05);
    do_fall();
    chk("two_fall2_datain", datain, 8'h10);
    chk("two_fall2_idx", entry_idx, 2'd1);
    do_fall();
    chk("two_done", done, 1'b1);
    chk("two_end_busy", busy, 1'b0);

    // Loop and stop
    wr(2'd0, 8'h02, 8'd1); wr(2'd1, 8'h03, 8'd1);
    wr(2'd2, 8'h04, 8'd1); wr(2'd3, 8'h05, 8'd1);
    do_start(2'd3, 1'b1);
    chk("loop_idx0", entry_idx, 2'd0);
    chk("loop_datain0", datain, 8'h02);
    for (int k = 0; k < 6; k++) begin
      do_fall();
      chk($sformatf("loop_idx_fall%0d", k + 1), entry_idx, loop_seq[k]);
    end
    stop = 1'b1; @(negedge clock); stop = 1'b0;
    chk("loop_stop_busy", busy, 1'b1);
    chk("loop_stop_datain", datain, 8'h04);
    do_fall();
    chk("loop_stop_done", done, 1'b1);
    chk("loop_stop_hold", datain, 8'h04);
    chk("loop_stop_idle", busy, 1'b0);

    // Stop landing on an advance boundary
    wr(2'd0, 8'h21, 8'd1); wr(2'd1, 8'h22, 8'd1);
    do_start(2'd1, 1'b1);
    fall_with_stop();
    chk("stopadv_idx", entry_idx, 2'd1);
    chk("stopadv_datain", datain, 8'h22);
    chk("stopadv_busy", busy, 1'b1);
    do_fall();
    chk("stopadv_done", done, 1'b1);
    chk("stopadv_hold", datain, 8'h22);

    // Zero values and simultaneous events
    wr(2'd0, 8'h00, 8'd0); wr(2'd1, 8'h07, 8'd2);
    start = 1'b1; stop = 1'b1; cfg_last = 2'd1; cfg_loop = 1'b0;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 1'b0);
    do_start(2'd1, 1'b0);
    chk("zero_datain", datain, 8'h01);
    do_fall();
    chk("zero_adv_idx", entry_idx, 2'd1);
    chk("zero_adv_datain", datain, 8'h07);
    start = 1'b1; cfg_last = 2'd0; cfg_loop = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("run_start_idx", entry_idx, 2'd1);
    chk("run_start_datain", datain, 8'h07);
    do_fall();
    chk("zero_dwell2_busy", busy, 1'b1);
    do_fall();
    chk("zero_end_done", done, 1'b1);

    // Reset mid-run
    wr(2'd0, 8'h02, 8'd1); wr(2'd1, 8'h03, 8'd1);
    wr(2'd2, 8'h04, 8'd1); wr(2'd3, 8'h05, 8'd1);
    do_start(2'd3, 1'b0);
    do_fall(); do_fall();
    chk("midrst_pre_idx", entry_idx, 2'd2);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_datain", datain, 8'h01);
    chk("midrst_idx", entry_idx, 2'd0);
    chk("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    do_start(2'd3, 1'b0);
    chk("midrst_restart_datain", datain, 8'h01);
    chk("midrst_restart_busy", busy, 1'b1);
    do_fall();
    chk("midrst_cleared_idx", entry_idx, 2'd1);
    chk("midrst_cleared_datain", datain, 8'h01);

    repeat (3) @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
